// File: rtl/usrt_pkg.sv
// Shared USRT definitions: the default baud divisor width, the minimum divisor
// and the divisor type used by the baud generator and the TX/RX blocks.
package usrt_pkg;
    localparam int USRT_WIDTH   = 14;
    localparam int USRT_MIN_DIV = 2;

    typedef logic [USRT_WIDTH-1:0] div_t;
endpackage

// File: rtl/baudgen_if.sv
// Baud generator control/status bundle: the requested divisor and the two
// registered timing outputs.
interface baudgen_if
    import usrt_pkg::*;
#(
    parameter int WIDTH = USRT_WIDTH
) ();
    logic [WIDTH-1:0] i_Baud;
    logic             o_Bclk;
    logic             o_Tick;

    modport master (output i_Baud, input o_Bclk, input o_Tick);
    modport slave  (input i_Baud, output o_Bclk, output o_Tick);
endinterface

// File: rtl/baudgen.sv
// Programmable baud clock generator: divides i_Pclk by max(i_Baud, MIN_DIV),
// giving a near-50% baud clock and a one-cycle tick at each period start.
module baudgen
    import usrt_pkg::*;
#(
    parameter int WIDTH   = USRT_WIDTH,
    parameter int MIN_DIV = USRT_MIN_DIV
) (
    input  logic      i_Pclk,
    input  logic      i_Rstn,
    baudgen_if.slave  bus
);
    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             load_q, load_d;
    logic             bclk_q, bclk_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] baud_eff;
    logic [WIDTH-1:0] cnt_inc;
    logic             boundary;

    always_comb begin
        baud_eff = (bus.i_Baud < MIN_DIV_W) ? MIN_DIV_W : bus.i_Baud;
        cnt_inc  = cnt_q + ONE;
        // div_q is always >= MIN_DIV, so div_q-1 cannot underflow
        boundary = load_q || (cnt_q == (div_q - ONE));

        cnt_d  = cnt_inc;
        div_d  = div_q;
        load_d = load_q;
        tick_d = 1'b0;
        bclk_d = (cnt_inc < (div_q >> 1));

        if (boundary) begin
            // The requested divisor is only picked up here, so the running
            // period is never cut short or stretched.
            div_d  = baud_eff;
            cnt_d  = '0;
            load_d = 1'b0;
            tick_d = 1'b1;
            bclk_d = 1'b1;
        end
    end

    always_ff @(posedge i_Pclk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            cnt_q  <= '0;
            div_q  <= MIN_DIV_W;
            load_q <= 1'b1;
            bclk_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            load_q <= load_d;
            bclk_q <= bclk_d;
            tick_q <= tick_d;
        end
    end

    assign bus.o_Bclk = bclk_q;
    assign bus.o_Tick = tick_q;
endmodule

// File: tb/tb_baudgen.sv
// Self-checking bench for baudgen: a period-level reference model builds the
// expected output sequence for each baud period from the sampled divisor.
`timescale 1ns/1ps
module tb_baudgen;
    import usrt_pkg::*;

    logic clk;
    logic rst_n;

    baudgen_if #(.WIDTH(USRT_WIDTH)) bus ();

    baudgen #(.WIDTH(USRT_WIDTH), .MIN_DIV(USRT_MIN_DIV)) dut (
        .i_Pclk (clk),
        .i_Rstn (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected outputs, one entry per cycle: bit1 = tick, bit0 = bclk.
    int exp_q[$];
    bit tick_seen;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // A new period begins whenever the previous one is used up: it lasts D
    // cycles, high for D/2 (tick in the first), low for the rest.
    task automatic model_edge();
        int d;
        if (exp_q.size() == 0) begin
            d = (int'(bus.i_Baud) < USRT_MIN_DIV) ? USRT_MIN_DIV : int'(bus.i_Baud);
            for (int k = 0; k < d; k++)
                exp_q.push_back((k < d / 2) ? ((k == 0) ? 3 : 1) : 0);
        end
    endtask

    task automatic step();
        int e;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        tick_seen = bus.o_Tick;
        if (rst_n) begin
            e = exp_q.pop_front();
            check_eq("bclk", int'(bus.o_Bclk), e & 1);
            check_eq("tick", int'(bus.o_Tick), (e >> 1) & 1);
        end else begin
            check_eq("bclk_rst", int'(bus.o_Bclk), 0);
            check_eq("tick_rst", int'(bus.o_Tick), 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Waits for the next tick, then counts cycles to the following one.
    task automatic measure_gap(input string tag, input int exp_gap);
        int n;
        n = 0;
        tick_seen = 1'b0;
        while (!tick_seen && n < 20000) begin step(); n++; end
        check_eq({tag, "_found"}, int'(tick_seen), 1);
        n = 0;
        tick_seen = 1'b0;
        while (!tick_seen && n < 20000) begin step(); n++; end
        check_eq(tag, n, exp_gap);
    endtask

    initial begin
        div_t b;
        rst_n      = 1'b0;
        bus.i_Baud = 87;
        #230;
        check_eq("reset_bclk", int'(bus.o_Bclk), 0);
        check_eq("reset_tick", int'(bus.o_Tick), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release is a period start.
        step();
        check_eq("first_rise", int'(bus.o_Bclk), 1);
        run(86);
        measure_gap("gap87", 87);

        // Mid-period change: current 87-cycle period still completes.
        run(30);
        bus.i_Baud = 20;
        run(57);
        measure_gap("gap20", 20);

        bus.i_Baud = 0;
        run(10);
        bus.i_Baud = 1;
        run(10);
        measure_gap("gap_min", 2);
        bus.i_Baud = 3;
        run(10);
        measure_gap("gap3", 3);

        // Randomized divisor changes at arbitrary points.
        for (int s = 0; s < 30; s++) begin
            b = div_t'($urandom_range(0, 40));
            bus.i_Baud = b;
            run($urandom_range(1, 70));
        end

        // Asynchronous reset mid-period.
        bus.i_Baud = 9;
        run(25);
        #20;
        rst_n = 1'b0;
        #1;
        check_eq("async_bclk", int'(bus.o_Bclk), 0);
        check_eq("async_tick", int'(bus.o_Tick), 0);
        exp_q.delete();
        run(2);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("restart_tick", int'(bus.o_Tick), 1);
        run(8);
        step();
        check_eq("restart_period", int'(bus.o_Tick), 1);

        bus.i_Baud = 16383;
        measure_gap("gap_max", 16383);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/baudgen.md
# baudgen

Programmable baud-rate clock generator for the USRT. It divides the system clock `i_Pclk` by a runtime-selectable integer `i_Baud` and produces two outputs:
- `o_Bclk`, a registered, near-50 % duty baud clock;
- `o_Tick`, a one-cycle strobe marking each baud-period start.

It feeds the transmitter and receiver shift logic. Example: at 10 MHz, `i_Baud = 87` gives about 115 200 Bd.

## Interface
- `WIDTH`, default 14: width of the divisor input and internal counter.
- `MIN_DIV`, default 2: smallest effective divisor; smaller requests are clamped up to it.

Ports:
- `i_Pclk`  in  1  system clock; all logic is on its rising edge.
- `i_Rstn`  in  1  reset, asynchronous, active-low.
- `i_Baud`  in  WIDTH  requested divisor N; one baud period is N `i_Pclk` cycles.
- `o_Bclk`  out  1  divided clock, registered.
- `o_Tick`  out  1  one-cycle pulse, high in the first cycle of every baud period.

## Operation
Internal state:
- `cnt`: WIDTH bits, the position within the current period.
- `div`: WIDTH bits, the divisor currently in effect.
- `load`: 1 bit, pending divisor load.

Divisor sampling:
- The effective divisor is D = max(`i_Baud`, `MIN_DIV`).
- D is sampled only at a period boundary. A change of `i_Baud` mid-period never shortens or stretches the current period; it takes effect at the next period start.

Behaviour at each rising edge of `i_Pclk`:
- If `load` = 1 or `cnt` = `div`−1 (period boundary):
  - `div` <= D;
  - `cnt` <= 0;
  - `load` <= 0;
  - `o_Tick` <= 1;
  - `o_Bclk` <= 1.
- Otherwise:
  - `cnt` <= `cnt`+1;
  - `o_Tick` <= 0;
  - `o_Bclk` <= (`cnt`+1 < `div`>>1).

Duty cycle:
- `o_Bclk` is high for floor(D/2) cycles and low for ceil(D/2) cycles.
- D = 87 gives 43 cycles high and 44 low.
- D = 2 gives 1 high and 1 low.

Arithmetic:
- `cnt` never exceeds `div`−1, so no wrap-around is possible.
- All comparisons are unsigned and WIDTH bits wide.
- The maximum divisor is 2^WIDTH − 1 (16383).

## Timing
Reset values, applied asynchronously while `i_Rstn` = 0:
- `cnt` = 0;
- `div` = `MIN_DIV`;
- `load` = 1;
- `o_Bclk` = 0;
- `o_Tick` = 0.

Start-up after reset:
- The first rising edge after `i_Rstn` is released is a period boundary.
- `o_Bclk` and `o_Tick` go high one edge after reset deassertion, with no extra latency.

Steady state:
- Rising edges of `o_Bclk` are exactly D `i_Pclk` cycles apart.
- `o_Tick` coincides with each rising edge of `o_Bclk`.

Other rules:
- Reset asserted mid-period forces the outputs to 0 immediately. The next period restarts cleanly on the first edge after release.
- Outputs come straight from flip-flops and are glitch-free.

## Structure
- A shared `usrt_pkg` holds:
  - the `WIDTH` default (14);
  - `MIN_DIV` (2);
  - a divisor typedef (`logic [WIDTH-1:0]`), reused by the TX and RX blocks.
- The design is a single module with no sub-modules.
- The clamp D = max(`i_Baud`, `MIN_DIV`) is a combinational expression inside the module.

## Test plan
1. `i_Pclk` period 100 ns, `i_Baud` = 87, reset released:
   - first `o_Bclk` rise on the first clock edge;
   - subsequent rises every 8700 ns;
   - `o_Bclk` high 4300 ns, low 4400 ns;
   - `o_Tick` high for 100 ns at each rise.
2. After three `o_Bclk` rises, change `i_Baud` to 20 mid-period:
   - the current period still completes at 87 cycles;
   - later periods are 20 cycles (2000 ns), high 10 and low 10.
3. `i_Baud` = 0 and then 1: the period is 2 cycles, with `o_Bclk` alternating 1,0 and `o_Tick` on every rise.
4. `i_Baud` = 3: period 3 cycles, with `o_Bclk` high 1 cycle and low 2.
5. Assert `i_Rstn` low mid-period:
   - `o_Bclk` and `o_Tick` drop to 0 at once, without waiting for a clock edge;
   - after release, the first edge gives `o_Bclk` = 1 and `o_Tick` = 1, and a full period follows.
6. `i_Baud` = 16383: the period is exactly 16383 cycles, with no counter overflow.
